// File: rtl/rv_fetch_pkg.sv
// Shared types for the RV instruction-fetch sequencer.
// RV_FETCH_PIPE_EN (optional) enables a second outstanding read.
package rv_fetch_pkg;

    localparam int RV_PC_W = 30;

    typedef logic [RV_PC_W-1:0] pc_t;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_HALT
    } fetch_state_t;

    localparam logic [1:0] PIPE_MAX_OUTSTANDING = 2'd2;

endpackage

// File: rtl/rv_fetch_pc_gen.sv
// Fetch PC register with word incrementer and redirect mux.
// Redirect has priority over a normal advance.
module rv_fetch_pc_gen
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_redirect,
    input  pc_t  i_redirect_pc,
    input  logic i_advance,
    output pc_t  o_pc,
    output pc_t  o_pc_p1
);

    pc_t pc_q;

    // Word address arithmetic wraps naturally at 30 bits.
    assign o_pc_p1 = pc_q + pc_t'(1);
    assign o_pc    = pc_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc_q <= RESET_VECTOR[31:2];
        end else if (i_redirect) begin
            pc_q <= i_redirect_pc;
        end else if (i_advance) begin
            pc_q <= o_pc_p1;
        end
    end

endmodule

// File: rtl/rv_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues bus reads, handles redirect/drain/fault.
// Define RV_FETCH_PIPE_EN to allow a second read in flight while waiting.
module rv_fetch_ctrl
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_redirect,
    input  logic [RV_PC_W-1:0] i_redirect_pc,
    input  logic               i_hold,
    output logic               o_ibus_req,
    output logic [RV_PC_W-1:0] o_ibus_addr,
    input  logic               i_ibus_gnt,
    input  logic               i_ibus_rvalid,
    input  logic               i_ibus_err,
    output logic [RV_PC_W-1:0] o_pc,
    output logic [RV_PC_W-1:0] o_pc_p4,
    output logic               o_stall,
    output logic               o_flush,
    output logic               o_fault,
    output logic [RV_PC_W-1:0] o_fault_pc
);

    fetch_state_t state;
    logic [1:0]   outstanding;
    logic [1:0]   outstanding_nxt;
    logic         fire;
    logic         resp;
    logic         deliver;
    logic         bus_fault;
    pc_t          pc;
    pc_t          pc_p1;

    rv_fetch_pc_gen #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_gen (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_advance     (deliver),
        .o_pc          (pc),
        .o_pc_p1       (pc_p1)
    );

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves a latch.
        o_ibus_req = 1'b0;
        case (state)
            ST_ISSUE: o_ibus_req = !i_hold;
`ifdef RV_FETCH_PIPE_EN
            ST_WAIT:  o_ibus_req = !i_hold && (outstanding < PIPE_MAX_OUTSTANDING);
`endif
            default:  o_ibus_req = 1'b0;
        endcase
        if (i_redirect) begin
            o_ibus_req = 1'b0;
        end
    end

    assign fire      = o_ibus_req && i_ibus_gnt;
    assign resp      = i_ibus_rvalid && (outstanding != 2'd0);
    assign deliver   = (state == ST_WAIT) && i_ibus_rvalid && !i_ibus_err && !i_redirect;
    assign bus_fault = (state == ST_WAIT) && i_ibus_rvalid &&  i_ibus_err && !i_redirect;

    assign outstanding_nxt = outstanding + {1'b0, fire} - {1'b0, resp};

    // pc tracks the oldest in-flight word, so the next request is pc + reads already in flight;
    // the sum stays constant while a request waits for its grant.
    assign o_ibus_addr = pc + pc_t'(outstanding);
    assign o_pc        = pc;
    assign o_pc_p4     = pc_p1;
    assign o_stall     = !deliver || i_hold;
    assign o_flush     = i_redirect || (state == ST_RESET) || (state == ST_DRAIN);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_RESET;
            outstanding <= 2'd0;
            o_fault     <= 1'b0;
            o_fault_pc  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            outstanding <= outstanding_nxt;
            if (i_redirect) begin
                o_fault <= 1'b0;
                state   <= (outstanding_nxt != 2'd0) ? ST_DRAIN : ST_ISSUE;
            end else begin
                case (state)
                    ST_RESET: state <= ST_ISSUE;
                    ST_ISSUE: if (fire) state <= ST_WAIT;
                    ST_WAIT: begin
                        if (bus_fault) begin
                            state      <= ST_HALT;
                            o_fault    <= 1'b1;
                            o_fault_pc <= pc;
                        end else if (outstanding_nxt == 2'd0) begin
                            state <= ST_ISSUE;
                        end
                    end
                    ST_DRAIN: if (outstanding_nxt == 2'd0) state <= ST_ISSUE;
                    ST_HALT:  state <= ST_HALT;
                    default:  state <= ST_RESET;
                endcase
            end
        end
    end

endmodule
